// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC stage: holds the fetch PC, issues one outstanding
// instruction-memory request at a time and queues returned words with their
// PC toward decode. A redirect reloads the PC, flushes the queue and marks any
// in-flight response as stale so it is discarded on arrival.
module fetch_pc_unit #(
    parameter int unsigned          WordSize = 32,
    parameter logic [WordSize-1:0]  ResetVec = '0,
    parameter int unsigned          QDepth   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect,
    input  logic [WordSize-1:0] redirect_addr,
    output logic                imem_req,
    output logic [WordSize-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic                imem_rvalid,
    input  logic [WordSize-1:0] imem_rdata,
    output logic                instr_valid,
    output logic [WordSize-1:0] instr,
    output logic [WordSize-1:0] instr_pc,
    input  logic                instr_ready
);

    localparam int unsigned PtrW = (QDepth > 1) ? $clog2(QDepth) : 1;
    localparam int unsigned CntW = $clog2(QDepth + 1);

    // REQ: may issue; WAIT: live response pending; DROP: stale response pending
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t              state;
    logic [WordSize-1:0] pc_q;
    logic [WordSize-1:0] req_pc;

    logic [WordSize-1:0] fifo_instr [QDepth];
    logic [WordSize-1:0] fifo_pc    [QDepth];
    logic [PtrW-1:0]     rd_ptr;
    logic [PtrW-1:0]     wr_ptr;
    logic [CntW-1:0]     count;

    logic handshake;
    logic push;
    logic pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(QDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Request and decode-side handshakes; redirect does not gate the request
    assign imem_req    = (state == REQ) && (count < CntW'(QDepth)) && !rst;
    assign imem_addr   = pc_q;
    assign handshake   = imem_req && imem_ready;
    assign push        = (state == WAIT) && imem_rvalid && !redirect;
    assign instr_valid = (count != '0) && !rst;
    assign pop         = instr_valid && instr_ready;
    assign instr       = fifo_instr[rd_ptr];
    assign instr_pc    = fifo_pc[rd_ptr];

    // Fetch FSM and PC; a redirect always wins the PC update
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= REQ;
            pc_q   <= ResetVec;
            req_pc <= ResetVec;
        end else begin
            case (state)
                REQ: begin
                    if (handshake) begin
                        req_pc <= pc_q;
                        state  <= redirect ? DROP : WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state <= REQ;
                        if (!redirect) begin
                            pc_q <= req_pc + WordSize'(4);
                        end
                    end else if (redirect) begin
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
            if (redirect) begin
                pc_q <= redirect_addr;
            end
        end
    end

    // Queue occupancy and pointers; flush beats same-cycle push/pop
    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CntW'(push) - CntW'(pop);
        end
    end

    // Queue storage, no reset needed since occupancy qualifies it
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= req_pc;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: a behavioural memory, a scoreboard queue of expected
// decode entries, a vector table for the streaming case and directed sequences
// for redirect, wrap-around and reset corner cases, then a randomized phase.
module tb_fetch_pc_unit;

    localparam logic [31:0] RVEC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    fetch_pc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    typedef struct {
        logic        in_imem_ready;
        logic        in_instr_ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } row_t;

    int          checks = 0;
    int          failures = 0;
    ent_t        sb[$];
    logic [31:0] exp_pc = RVEC;
    bit          outstanding = 0;
    bit          stale = 0;
    logic [31:0] req_addr = '0;
    int          lat_cnt = 0;
    int          mem_lat = 0;
    bit          force_rv = 0;
    bit          saw_bad = 0;
    row_t        tbl[7];

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for imem_req (t=%0t)", name, $time);
    endtask

    // Memory model: fixed-latency responder for the single outstanding request
    task automatic drive_mem();
        imem_rvalid = force_rv || (outstanding && lat_cnt == 0);
        imem_rdata  = outstanding ? word(req_addr) : $urandom;
    endtask

    // Drive memory, compare at the falling edge, then advance the reference model
    task automatic sample();
        bit exp_req;
        bit exp_valid;
        bit hs;
        bit pop;
        bit rv;
        drive_mem();
        @(negedge clk);
        exp_req   = !rst && !outstanding && (sb.size() < 2);
        exp_valid = !rst && (sb.size() != 0);
        chk("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req && imem_req) chk("imem_addr", imem_addr, exp_pc);
        chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
        if (exp_valid && instr_valid) begin
            chk("instr_pc", instr_pc, sb[0].pc);
            chk("instr", instr, sb[0].ins);
        end
        if (instr_valid && instr_pc == 32'h10) saw_bad = 1;

        rv  = imem_rvalid;
        hs  = exp_req && imem_ready;
        pop = exp_valid && instr_ready;
        if (rst) begin
            sb.delete();
            outstanding = 0;
            stale = 0;
            exp_pc = RVEC;
        end else begin
            if (pop) void'(sb.pop_front());
            if (rv && outstanding) begin
                if (!stale && !redirect) begin
                    sb.push_back({req_addr, word(req_addr)});
                    exp_pc = req_addr + 32'd4;
                end
                outstanding = 0;
                stale = 0;
            end else if (outstanding) begin
                if (lat_cnt > 0) lat_cnt--;
                if (redirect) stale = 1;
            end
            if (hs) begin
                outstanding = 1;
                req_addr = exp_pc;
                lat_cnt = mem_lat;
                stale = redirect;
            end
            if (redirect) begin
                sb.delete();
                exp_pc = redirect_addr;
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        redirect = 1'b0;
        force_rv = 1'b0;
    endtask

    task automatic cyc();
        sample();
        adv();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic wait_req(input string name, input logic [31:0] exp);
        bit got = 0;
        for (int i = 0; i < 12; i++) begin
            sample();
            if (imem_req) begin
                chk(name, imem_addr, exp);
                got = 1;
            end
            adv();
            if (got) break;
        end
        if (!got) timeout_fail(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // streaming vectors: {imem_ready, instr_ready, req, addr, valid, pc}
        tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h8, 1'b1, 32'h4};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'hC, 1'b1, 32'h8};

        @(posedge clk);
        #1;
        do_reset();
        sample();
        chk("reset_addr", imem_addr, RVEC);
        chk("reset_valid", 32'(instr_valid), 32'h0);
        adv();
        do_reset();

        // zero-wait streaming
        mem_lat = 0;
        foreach (tbl[i]) begin
            imem_ready  = tbl[i].in_imem_ready;
            instr_ready = tbl[i].in_instr_ready;
            sample();
            chk("tbl_req", 32'(imem_req), 32'(tbl[i].e_req));
            if (tbl[i].e_req) chk("tbl_addr", imem_addr, tbl[i].e_addr);
            chk("tbl_valid", 32'(instr_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk("tbl_pc", instr_pc, tbl[i].e_pc);
                chk("tbl_instr", instr, word(tbl[i].e_pc));
            end
            adv();
        end

        // backpressure: queue fills to two and fetch stalls
        do_reset();
        imem_ready = 1'b1;
        instr_ready = 1'b0;
        repeat (4) cyc();
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("bp_req_stall", 32'(imem_req), 32'h0);
            chk("bp_head_pc", instr_pc, 32'h0);
            adv();
        end
        instr_ready = 1'b1;
        sample();
        chk("bp_rel_pc0", instr_pc, 32'h0);
        chk("bp_rel_req0", 32'(imem_req), 32'h0);
        adv();
        sample();
        chk("bp_rel_pc4", instr_pc, 32'h4);
        chk("bp_rel_req1", 32'(imem_req), 32'h1);
        chk("bp_resume_addr", imem_addr, 32'h8);
        adv();
        repeat (4) cyc();

        // redirect while WAIT: 0x10 response dropped
        do_reset();
        saw_bad = 0;
        imem_ready = 1'b0;
        redirect = 1'b1;
        redirect_addr = 32'h10;
        cyc();
        imem_ready = 1'b1;
        mem_lat = 2;
        sample();
        chk("drop_issue_addr", imem_addr, 32'h10);
        adv();
        mem_lat = 0;
        redirect = 1'b1;
        redirect_addr = 32'h200;
        cyc();
        wait_req("drop_next_addr", 32'h200);
        repeat (6) cyc();
        chk("drop_never_seen", 32'(saw_bad), 32'h0);

        // redirect in the same cycle as a live response
        do_reset();
        instr_ready = 1'b0;
        imem_ready = 1'b1;
        mem_lat = 0;
        repeat (3) cyc();
        redirect = 1'b1;
        redirect_addr = 32'h80;
        cyc();
        sample();
        chk("rv_redir_req", 32'(imem_req), 32'h1);
        chk("rv_redir_addr", imem_addr, 32'h80);
        chk("rv_redir_flush", 32'(instr_valid), 32'h0);
        adv();
        instr_ready = 1'b1;
        repeat (4) cyc();

        // PC wrap-around
        do_reset();
        imem_ready = 1'b0;
        redirect = 1'b1;
        redirect_addr = 32'hFFFF_FFFC;
        cyc();
        imem_ready = 1'b1;
        cyc();
        cyc();
        sample();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_head_pc", instr_pc, 32'hFFFF_FFFC);
        adv();
        repeat (3) cyc();

        // redirect with same-cycle handshake, then a second redirect in DROP
        do_reset();
        mem_lat = 2;
        redirect = 1'b1;
        redirect_addr = 32'h40;
        cyc();
        mem_lat = 0;
        redirect = 1'b1;
        redirect_addr = 32'h60;
        cyc();
        wait_req("drop_reredirect_addr", 32'h60);
        repeat (3) cyc();

        // reset mid-fetch, then a stray response in REQ
        do_reset();
        instr_ready = 1'b0;
        mem_lat = 0;
        cyc();
        cyc();
        mem_lat = 3;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        imem_ready = 1'b0;
        force_rv = 1'b1;
        sample();
        chk("rst_mid_valid", 32'(instr_valid), 32'h0);
        chk("rst_mid_addr", imem_addr, RVEC);
        adv();
        sample();
        chk("stray_rv_valid", 32'(instr_valid), 32'h0);
        chk("stray_rv_addr", imem_addr, RVEC);
        adv();
        mem_lat = 0;
        imem_ready = 1'b1;
        instr_ready = 1'b1;
        repeat (4) cyc();

        // randomized traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            imem_ready  = ($urandom % 4) != 0;
            instr_ready = ($urandom % 3) != 0;
            mem_lat     = $urandom % 3;
            redirect    = ($urandom % 10) == 0;
            redirect_addr = (($urandom % 8) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
